efb_wb_arbiter: RTL and testbench
=================================

Name: efb_wb_arbiter

Overview:
- Round-robin arbiter that shares the single EFB Wishbone slave port (I2C/SPI/timer/UFM register file) between NUM_REQ register-access requesters, e.g. the I2C slave sequencer and a config/UFM loader.
- Adds an optional per-requester lock so multi-access sequences (SR poll then RXDR read) are not interleaved.
- Adds an ack timeout so a hung EFB access cannot stall the design.
- Sits between the requester FSMs and the EFB instance, on the internal oscillator clock domain.

Parameters:
- NUM_REQ, 2: number of requesters; legal range 2..4.
- ADR_W, 8: Wishbone address width.
- DAT_W, 8: Wishbone data width.
- TIMEOUT_CYCLES, 255: cycles in ACCESS without ack before forced termination; 0 disables the timeout.

Ports:
- clk  in  1  system clock (internal oscillator).
- RST_N  in  1  synchronous active-low reset.
- req_stb  in  NUM_REQ  per-requester access request; held until that requester's ack or err.
- req_we  in  NUM_REQ  per-requester write enable.
- req_lock  in  NUM_REQ  keep grant after the current access completes.
- req_adr  in  NUM_REQ*ADR_W  flattened addresses; requester i uses [i*ADR_W +: ADR_W].
- req_dat  in  NUM_REQ*DAT_W  flattened write data.
- req_ack  out  NUM_REQ  one-cycle completion pulse to the granted requester.
- req_err  out  NUM_REQ  one-cycle timeout pulse to the granted requester.
- req_rdat  out  DAT_W  read data, broadcast to all requesters, valid when req_ack or req_err is high.
- grant  out  NUM_REQ  one-hot current owner; 0 when idle.
- wb_stb_o  out  1  to EFB wb_stb_i.
- wb_cyc_o  out  1  to EFB wb_cyc_i; always equals wb_stb_o.
- wb_we_o  out  1  to EFB wb_we_i.
- wb_adr_o  out  ADR_W  to EFB wb_adr_i.
- wb_dat_o  out  DAT_W  to EFB wb_dat_i.
- wb_dat_i  in  DAT_W  from EFB wb_dat_o.
- wb_ack_i  in  1  from EFB wb_ack_o.

Behaviour:
- Clocking and reset: all state on posedge clk. RST_N low at an edge forces all outputs to 0, state to IDLE, lock owner cleared, timeout counter cleared, and last_grant to NUM_REQ-1 (requester 0 wins first). Reset mid-access drops wb_stb_o at that edge and does not pulse ack or err.
- States: IDLE, ACCESS, GAP.
- IDLE, candidate set:
  - If a lock owner exists and its req_stb is high: owner only.
  - If a lock owner exists and its req_stb is low: none; the owner keeps the grant until it deasserts req_lock, then the lock clears in IDLE.
  - Otherwise: all requesters with req_stb high.
- IDLE, grant: winner is the first candidate searching from last_grant+1 modulo NUM_REQ. At that edge, register the winner's adr/we/dat into wb_*_o, set wb_stb_o=wb_cyc_o=1, set grant one-hot, update last_grant, clear the counter, go to ACCESS. Latency from req_stb high to wb_stb_o high is exactly 1 cycle.
- ACCESS: wb_adr_o, wb_we_o and wb_dat_o stay stable. Requester inputs are not re-sampled, so a requester dropping req_stb mid-access is ignored and the access completes normally.
- ACCESS, ack: on wb_ack_i=1, at that edge req_rdat<=wb_dat_i, req_ack[g]<=1, wb_stb_o/wb_cyc_o<=0, wb_we_o<=0, wb_adr_o<=0, wb_dat_o<=0. Sample req_lock[g] into the lock owner (set or clear). Go to GAP.
- ACCESS, timeout: when TIMEOUT_CYCLES>0 and the counter reaches TIMEOUT_CYCLES-1 with wb_ack_i=0, do the same as ack except req_err[g]<=1 (no ack pulse), req_rdat<=0, and clear the lock owner.
- Ack and timeout in the same cycle: ack wins, no err.
- GAP: exactly one cycle with wb_stb_o low, which gives the EFB its required stb gap and lets the requester drop req_stb. req_ack and req_err return to 0. grant stays on the owner only if locked, else 0. Go to IDLE.
- Back-to-back accesses: minimum period per access is 3 cycles plus EFB ack latency.
- Counter: width ceil(log2(TIMEOUT_CYCLES+1)); saturates and never wraps.
- Fairness: with all requesters continuously requesting and unlocked, grants rotate 0,1,...,NUM_REQ-1,0.

Test Plan:
- Single requester: req0 write adr 0x4A dat 0x80 -> wb_stb_o high 1 cycle later with adr 0x4A, we=1, dat 0x80. EFB acks after 2 cycles -> req_ack[0] pulses 1 cycle, then wb_stb_o low for at least 1 cycle.
- Read path: req1 read adr 0x4E, EFB returns 0x5A with ack -> req_rdat=0x5A while req_ack[1]=1; req_err stays 0.
- Contention: req0 and req1 high in the same cycle after reset -> req0 served first, then req1. Both re-requesting continuously -> grant order 0,1,0,1.
- Lock: req0 with req_lock=1 while req1 waits; req0 issues 3 accesses -> req1 not granted until req0 drops req_lock; then req1 granted on the next IDLE.
- Timeout: TIMEOUT_CYCLES=8, EFB never acks -> wb_stb_o high exactly 8 cycles, req_err[g] pulses once with req_rdat=0x00, lock cleared. Separate case with ack in the 8th cycle -> req_ack only.
- Reset mid-access: RST_N low during ACCESS -> wb_stb_o=0 next edge, no ack or err. After release, requester 0 has priority.

Source files
------------

// File: rtl/efb_wb_arbiter.sv
// Round-robin arbiter sharing the EFB Wishbone slave port between NUM_REQ requesters,
// with per-requester lock for multi-access sequences and an ack timeout.
module efb_wb_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int ADR_W          = 8,
    parameter int DAT_W          = 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                     clk,
    input  logic                     RST_N,
    input  logic [NUM_REQ-1:0]       req_stb,
    input  logic [NUM_REQ-1:0]       req_we,
    input  logic [NUM_REQ-1:0]       req_lock,
    input  logic [NUM_REQ*ADR_W-1:0] req_adr,
    input  logic [NUM_REQ*DAT_W-1:0] req_dat,
    output logic [NUM_REQ-1:0]       req_ack,
    output logic [NUM_REQ-1:0]       req_err,
    output logic [DAT_W-1:0]         req_rdat,
    output logic [NUM_REQ-1:0]       grant,
    output logic                     wb_stb_o,
    output logic                     wb_cyc_o,
    output logic                     wb_we_o,
    output logic [ADR_W-1:0]         wb_adr_o,
    output logic [DAT_W-1:0]         wb_dat_o,
    input  logic [DAT_W-1:0]         wb_dat_i,
    input  logic                     wb_ack_i
);

    localparam int LW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic [CW-1:0] CNT_MAX  = '1;
    localparam logic          TO_EN    = (TIMEOUT_CYCLES > 0);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] GAP    = 2'd2;

    logic [1:0]         r_state;
    logic [LW-1:0]      r_last;
    logic [LW-1:0]      r_gidx;
    logic [LW-1:0]      r_lock_idx;
    logic               r_lock_vld;
    logic [CW-1:0]      r_cnt;

    logic [NUM_REQ-1:0] w_own_mask;
    logic [NUM_REQ-1:0] w_cand;
    logic [NUM_REQ-1:0] w_win_mask;
    logic [LW-1:0]      w_win;
    logic               w_found;
    logic               w_timeout;
    logic               w_lock_rel;

    assign wb_cyc_o = wb_stb_o;

    // Candidate set and round-robin search starting just after the last winner.
    always_comb begin
        w_own_mask = {{(NUM_REQ-1){1'b0}}, 1'b1} << r_lock_idx;
        w_cand     = r_lock_vld ? (req_stb & w_own_mask) : req_stb;
        w_found    = 1'b0;
        w_win      = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!w_found && w_cand[(int'(r_last) + k) % NUM_REQ]) begin
                w_found = 1'b1;
                w_win   = LW'((int'(r_last) + k) % NUM_REQ);
            end
        end
        w_win_mask = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_win;
        w_timeout  = TO_EN && (r_cnt == CNT_LAST) && !wb_ack_i;
        w_lock_rel = r_lock_vld && !req_stb[r_lock_idx] && !req_lock[r_lock_idx];
    end

    always_ff @(posedge clk) begin
        if (!RST_N) begin
            r_state    <= IDLE;
            r_last     <= LW'(NUM_REQ - 1);
            r_gidx     <= '0;
            r_lock_idx <= '0;
            r_lock_vld <= 1'b0;
            r_cnt      <= '0;
            req_ack    <= '0;
            req_err    <= '0;
            req_rdat   <= '0;
            grant      <= '0;
            wb_stb_o   <= 1'b0;
            wb_we_o    <= 1'b0;
            wb_adr_o   <= '0;
            wb_dat_o   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_lock_rel) begin
                        r_lock_vld <= 1'b0;
                        grant      <= '0;
                    end else if (w_found) begin
                        wb_stb_o <= 1'b1;
                        wb_we_o  <= req_we[w_win];
                        wb_adr_o <= req_adr[w_win*ADR_W +: ADR_W];
                        wb_dat_o <= req_dat[w_win*DAT_W +: DAT_W];
                        grant    <= w_win_mask;
                        r_gidx   <= w_win;
                        r_last   <= w_win;
                        r_cnt    <= '0;
                        r_state  <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (wb_ack_i || w_timeout) begin
                        wb_stb_o <= 1'b0;
                        wb_we_o  <= 1'b0;
                        wb_adr_o <= '0;
                        wb_dat_o <= '0;
                        r_state  <= GAP;
                        // Ack takes precedence over a timeout landing on the same edge.
                        if (wb_ack_i) begin
                            req_ack    <= grant;
                            req_rdat   <= wb_dat_i;
                            r_lock_vld <= req_lock[r_gidx];
                            r_lock_idx <= r_gidx;
                            if (!req_lock[r_gidx]) grant <= '0;
                        end else begin
                            req_err    <= grant;
                            req_rdat   <= '0;
                            r_lock_vld <= 1'b0;
                            grant      <= '0;
                        end
                    end else if (r_cnt != CNT_MAX) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                GAP: begin
                    req_ack <= '0;
                    req_err <= '0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_efb_wb_arbiter.sv
// Self-checking bench for efb_wb_arbiter: directed scenarios plus a randomized
// round-robin scoreboard against a transaction-level model.
module tb_efb_wb_arbiter;
    localparam int NR = 2;
    localparam int AW = 8;
    localparam int DW = 8;
    localparam int TO = 8;

    logic             clk = 1'b0;
    logic             RST_N;
    logic [NR-1:0]    req_stb, req_we, req_lock;
    logic [NR*AW-1:0] req_adr;
    logic [NR*DW-1:0] req_dat;
    logic [NR-1:0]    req_ack, req_err, grant;
    logic [DW-1:0]    req_rdat;
    logic             wb_stb_o, wb_cyc_o, wb_we_o;
    logic [AW-1:0]    wb_adr_o;
    logic [DW-1:0]    wb_dat_o;
    logic [DW-1:0]    wb_dat_i;
    logic             wb_ack_i;

    int n_pass = 0;
    int n_total = 0;

    int         efb_lat = 1;
    bit         efb_hang = 0;
    logic [7:0] efb_rdata = 8'h00;
    int         ecnt = 0;

    always #5 clk = ~clk;

    efb_wb_arbiter #(.NUM_REQ(NR), .ADR_W(AW), .DAT_W(DW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .RST_N(RST_N), .req_stb(req_stb), .req_we(req_we), .req_lock(req_lock),
        .req_adr(req_adr), .req_dat(req_dat), .req_ack(req_ack), .req_err(req_err),
        .req_rdat(req_rdat), .grant(grant), .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o),
        .wb_we_o(wb_we_o), .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
        .wb_ack_i(wb_ack_i)
    );

    // EFB model: acks after efb_lat cycles of stb high, unless hung.
    initial begin
        wb_ack_i = 1'b0;
        wb_dat_i = '0;
        forever begin
            @(posedge clk);
            #2;
            if (wb_stb_o === 1'b1) begin
                ecnt++;
                wb_ack_i = !efb_hang && (ecnt == efb_lat);
            end else begin
                ecnt = 0;
                wb_ack_i = 1'b0;
            end
            wb_dat_i = efb_rdata;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic int rr(int last, logic [NR-1:0] s);
        for (int k = 1; k <= NR; k++)
            if (s[(last + k) % NR]) return (last + k) % NR;
        return -1;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        req_stb = '0; req_we = '0; req_lock = '0; req_adr = '0; req_dat = '0;
    endtask

    task automatic do_reset;
        RST_N = 1'b0;
        idle_inputs();
        tick(); tick();
        RST_N = 1'b1;
        tick();
    endtask

    task automatic test_reset;
        RST_N = 1'b0;
        idle_inputs();
        tick(); tick();
        n_total++;
        if ({grant, req_ack, req_err, wb_stb_o, wb_cyc_o, wb_we_o} !== '0)
            $display("FAIL reset_ctrl: got %0h want 0", {grant, req_ack, req_err, wb_stb_o, wb_cyc_o, wb_we_o});
        else n_pass++;
        n_total++;
        if ({req_rdat, wb_adr_o, wb_dat_o} !== '0)
            $display("FAIL reset_data: got %0h want 0", {req_rdat, wb_adr_o, wb_dat_o});
        else n_pass++;
        RST_N = 1'b1;
        tick();
        n_total++;
        if ({wb_stb_o, grant} !== '0) $display("FAIL reset_idle: got %0h want 0", {wb_stb_o, grant});
        else n_pass++;
    endtask

    task automatic test_single_write;
        efb_lat = 2; efb_hang = 0;
        req_stb[0] = 1'b1; req_we[0] = 1'b1; req_adr[7:0] = 8'h4A; req_dat[7:0] = 8'h80;
        tick();
        n_total++;
        if ({wb_stb_o, wb_cyc_o, wb_we_o, wb_adr_o, wb_dat_o, grant} !== {3'b111, 8'h4A, 8'h80, 2'b01})
            $display("FAIL write_issue: got %0h want %0h", {wb_stb_o, wb_cyc_o, wb_we_o, wb_adr_o, wb_dat_o, grant},
                     {3'b111, 8'h4A, 8'h80, 2'b01});
        else n_pass++;
        tick();
        n_total++;
        if ({wb_stb_o, wb_adr_o, req_ack} !== {1'b1, 8'h4A, 2'b00})
            $display("FAIL write_hold: got %0h want %0h", {wb_stb_o, wb_adr_o, req_ack}, {1'b1, 8'h4A, 2'b00});
        else n_pass++;
        tick();
        n_total++;
        if ({req_ack, wb_stb_o, wb_cyc_o, wb_adr_o} !== {2'b01, 2'b00, 8'h00})
            $display("FAIL write_ack: got %0h want %0h", {req_ack, wb_stb_o, wb_cyc_o, wb_adr_o}, {2'b01, 2'b00, 8'h00});
        else n_pass++;
        req_stb[0] = 1'b0;
        tick();
        n_total++;
        if ({req_ack, wb_stb_o, grant} !== '0)
            $display("FAIL write_gap: got %0h want 0", {req_ack, wb_stb_o, grant});
        else n_pass++;
        idle_inputs();
        tick();
    endtask

    task automatic test_read;
        efb_lat = 1; efb_rdata = 8'h5A;
        req_stb[1] = 1'b1; req_we[1] = 1'b0; req_adr[15:8] = 8'h4E;
        tick();
        n_total++;
        if ({wb_stb_o, wb_we_o, wb_adr_o, grant} !== {2'b10, 8'h4E, 2'b10})
            $display("FAIL read_issue: got %0h want %0h", {wb_stb_o, wb_we_o, wb_adr_o, grant}, {2'b10, 8'h4E, 2'b10});
        else n_pass++;
        tick();
        n_total++;
        if ({req_ack, req_err, req_rdat} !== {2'b10, 2'b00, 8'h5A})
            $display("FAIL read_data: got %0h want %0h", {req_ack, req_err, req_rdat}, {2'b10, 2'b00, 8'h5A});
        else n_pass++;
        idle_inputs();
        tick(); tick();
    endtask

    task automatic test_contention;
        int ord[4] = '{0, 1, 0, 1};
        int n;
        do_reset();
        efb_lat = 1;
        req_adr = {8'h22, 8'h11};
        req_stb = 2'b11;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            while (wb_stb_o !== 1'b1 && n < 8) begin tick(); n++; end
            if (k == 0) begin
                n_total++;
                if (n !== 1) $display("FAIL first_latency: got %0d want 1", n);
                else n_pass++;
            end
            n_total++;
            if ({grant, wb_adr_o} !== {NR'(1 << ord[k]), (ord[k] == 0) ? 8'h11 : 8'h22})
                $display("FAIL rr_order%0d: got %0h want %0h", k, {grant, wb_adr_o},
                         {NR'(1 << ord[k]), (ord[k] == 0) ? 8'h11 : 8'h22});
            else n_pass++;
            n = 0;
            while (req_ack === '0 && n < 12) begin tick(); n++; end
            n_total++;
            if (req_ack !== NR'(1 << ord[k])) $display("FAIL rr_ack%0d: got %0h want %0h", k, req_ack, NR'(1 << ord[k]));
            else n_pass++;
        end
        idle_inputs();
        tick(); tick(); tick();
    endtask

    task automatic test_lock;
        int n;
        do_reset();
        efb_lat = 1;
        req_lock = 2'b01;
        req_stb = 2'b11;
        for (int k = 0; k < 3; k++) begin
            n = 0;
            while (wb_stb_o !== 1'b1 && n < 8) begin tick(); n++; end
            n_total++;
            if (grant !== 2'b01) $display("FAIL lock_grant%0d: got %0h want 1", k, grant);
            else n_pass++;
            n = 0;
            while (req_ack === '0 && n < 8) begin tick(); n++; end
            n_total++;
            if (req_ack !== 2'b01) $display("FAIL lock_ack%0d: got %0h want 1", k, req_ack);
            else n_pass++;
        end
        req_stb[0] = 1'b0;
        for (int j = 0; j < 4; j++) begin
            tick();
            n_total++;
            if ({grant, wb_stb_o} !== 3'b010) $display("FAIL lock_hold%0d: got %0h want 2", j, {grant, wb_stb_o});
            else n_pass++;
        end
        req_lock = 2'b00;
        n = 0;
        while (wb_stb_o !== 1'b1 && n < 6) begin tick(); n++; end
        n_total++;
        if ({wb_stb_o, grant} !== 3'b110) $display("FAIL lock_release: got %0h want 6", {wb_stb_o, grant});
        else n_pass++;
        n = 0;
        while (req_ack === '0 && n < 8) begin tick(); n++; end
        idle_inputs();
        tick(); tick();
    endtask

    task automatic test_timeout;
        int n;
        bit early;
        do_reset();
        efb_hang = 1; efb_rdata = 8'hA5;
        req_stb[0] = 1'b1; req_lock[0] = 1'b1; req_adr[7:0] = 8'h33;
        tick();
        n = 0; early = 0;
        while (wb_stb_o === 1'b1 && n < 20) begin
            if (req_err !== '0 || req_ack !== '0) early = 1;
            n++;
            tick();
        end
        n_total++;
        if (n !== TO || early) $display("FAIL timeout_len: got %0d want %0d (early=%0d)", n, TO, early);
        else n_pass++;
        n_total++;
        if ({req_err, req_ack, req_rdat, grant} !== {2'b01, 2'b00, 8'h00, 2'b00})
            $display("FAIL timeout_err: got %0h want %0h", {req_err, req_ack, req_rdat, grant},
                     {2'b01, 2'b00, 8'h00, 2'b00});
        else n_pass++;
        // Owner still holds req_lock: requester 1 gets in only if the lock was dropped.
        efb_hang = 0; efb_lat = 1;
        req_stb = 2'b10;
        tick();
        n_total++;
        if (req_err !== '0) $display("FAIL timeout_pulse: got %0h want 0", req_err);
        else n_pass++;
        n = 0;
        while (wb_stb_o !== 1'b1 && n < 6) begin tick(); n++; end
        n_total++;
        if (grant !== 2'b10) $display("FAIL timeout_unlock: got %0h want 2", grant);
        else n_pass++;
        n = 0;
        while (req_ack === '0 && n < 8) begin tick(); n++; end
        idle_inputs();
        tick(); tick();
    endtask

    task automatic test_timeout_ack;
        int n;
        efb_hang = 0; efb_lat = TO; efb_rdata = 8'h3C;
        req_stb[0] = 1'b1; req_adr[7:0] = 8'h44;
        tick();
        n = 0;
        while (wb_stb_o === 1'b1 && n < 20) begin n++; tick(); end
        n_total++;
        if ({req_ack, req_err, req_rdat} !== {2'b01, 2'b00, 8'h3C} || n !== TO)
            $display("FAIL ack_last_cycle: got %0h len %0d want %0h len %0d", {req_ack, req_err, req_rdat}, n,
                     {2'b01, 2'b00, 8'h3C}, TO);
        else n_pass++;
        idle_inputs();
        tick(); tick();
    endtask

    task automatic test_reset_mid;
        bit seen;
        int n;
        efb_lat = 5;
        req_stb = 2'b10; req_adr[15:8] = 8'h55;
        tick(); tick();
        RST_N = 1'b0;
        tick();
        n_total++;
        if ({wb_stb_o, grant, req_ack, req_err} !== '0)
            $display("FAIL rst_mid: got %0h want 0", {wb_stb_o, grant, req_ack, req_err});
        else n_pass++;
        tick();
        seen = (req_ack !== '0) || (req_err !== '0);
        RST_N = 1'b1;
        req_stb = 2'b11;
        tick();
        seen = seen || (req_ack !== '0) || (req_err !== '0);
        n_total++;
        if (seen) $display("FAIL rst_no_pulse: got pulse want none");
        else n_pass++;
        n = 0;
        while (wb_stb_o !== 1'b1 && n < 6) begin tick(); n++; end
        n_total++;
        if (grant !== 2'b01) $display("FAIL rst_priority: got %0h want 1", grant);
        else n_pass++;
        idle_inputs();
        n = 0;
        while (req_ack === '0 && n < 8) begin tick(); n++; end
        tick(); tick();
    endtask

    task automatic test_random;
        logic [AW-1:0] tadr[NR];
        logic [DW-1:0] tdat[NR];
        logic          twe[NR];
        logic [NR-1:0] prev;
        int cyc = 0, free_cyc = 0, ack_cyc = 0, owner = 0, mlast = NR - 1, cur_lat = 1, w;
        bit busy = 0, exp_rise;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < NR; i++) begin
                if (!req_stb[i] && $urandom_range(0, 2) == 0) begin
                    tadr[i] = AW'($urandom); tdat[i] = DW'($urandom); twe[i] = 1'($urandom);
                    req_adr[i*AW +: AW] = tadr[i];
                    req_dat[i*DW +: DW] = tdat[i];
                    req_we[i] = twe[i];
                    req_stb[i] = 1'b1;
                end
            end
            if (!busy) begin
                efb_lat = $urandom_range(1, 4);
                efb_rdata = 8'($urandom);
                cur_lat = efb_lat;
            end
            prev = req_stb;
            tick();
            cyc++;
            if (busy && cyc == ack_cyc) begin
                n_total++;
                if ({req_ack, req_err, req_rdat, wb_stb_o} !== {NR'(1 << owner), NR'(0), efb_rdata, 1'b0})
                    $display("FAIL rnd_ack cyc%0d: got %0h want %0h", cyc, {req_ack, req_err, req_rdat, wb_stb_o},
                             {NR'(1 << owner), NR'(0), efb_rdata, 1'b0});
                else n_pass++;
                busy = 0;
                free_cyc = cyc + 2;
                req_stb[owner] = 1'b0;
            end else if (busy) begin
                n_total++;
                if ({wb_stb_o, req_ack} !== {1'b1, NR'(0)})
                    $display("FAIL rnd_busy cyc%0d: got %0h want %0h", cyc, {wb_stb_o, req_ack}, {1'b1, NR'(0)});
                else n_pass++;
            end else begin
                exp_rise = (cyc >= free_cyc) && (prev != '0);
                n_total++;
                if (wb_stb_o !== exp_rise) $display("FAIL rnd_stb cyc%0d: got %0b want %0b", cyc, wb_stb_o, exp_rise);
                else n_pass++;
                if (exp_rise) begin
                    w = rr(mlast, prev);
                    n_total++;
                    if ({grant, wb_adr_o, wb_we_o, wb_dat_o} !== {NR'(1 << w), tadr[w], twe[w], tdat[w]})
                        $display("FAIL rnd_grant cyc%0d: got %0h want %0h", cyc, {grant, wb_adr_o, wb_we_o, wb_dat_o},
                                 {NR'(1 << w), tadr[w], twe[w], tdat[w]});
                    else n_pass++;
                    busy = 1; owner = w; mlast = w; ack_cyc = cyc + cur_lat;
                end
            end
        end
        idle_inputs();
        for (int k = 0; k < 8; k++) tick();
    endtask

    initial begin
        RST_N = 1'b0;
        idle_inputs();
        test_reset();
        test_single_write();
        test_read();
        test_contention();
        test_lock();
        test_timeout();
        test_timeout_ack();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
